// File: rtl/regfile_pkg.sv
// Shared defaults, register-file types and the write-port priority helper.
package regfile_pkg;

  localparam int RF_WIDTH     = 32;
  localparam int RF_ADDR_BITS = 5;
  localparam int RF_NREAD     = 2;
  localparam int RF_NWRITE    = 2;
  localparam int RF_MAX_PORTS = 16;

  typedef logic [RF_ADDR_BITS-1:0] rf_addr_t;
  typedef logic [RF_WIDTH-1:0]     rf_data_t;

  // Highest set bit wins, so the highest-indexed write port takes priority.
  function automatic int rf_onehot_winner(input logic [RF_MAX_PORTS-1:0] hits);
    int w;
    w = 0;
    for (int i = 0; i < RF_MAX_PORTS; i++) begin
      if (hits[i]) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_write_select.sv
// Per-register write arbitration: strobe, winning data and multi-port hit flag.
module regfile_write_select
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int NWRITE = RF_NWRITE
) (
  input  logic [NWRITE-1:0]       hit,
  input  logic [NWRITE-1:0]       en,
  input  logic [NWRITE*WIDTH-1:0] wdata,
  output logic                    strobe,
  output logic [WIDTH-1:0]        data,
  output logic                    multi_hit
);

  logic [NWRITE-1:0]       act;
  logic [RF_MAX_PORTS-1:0] act_ext;
  int                      winner;
  int                      n_act;

  always_comb begin
    act     = hit & en;
    act_ext = '0;
    act_ext[NWRITE-1:0] = act;
    winner  = rf_onehot_winner(act_ext);
    strobe  = |act;
    data    = wdata[winner*WIDTH +: WIDTH];
    n_act   = 0;
    for (int i = 0; i < NWRITE; i++) begin
      if (act[i]) n_act = n_act + 1;
    end
    multi_hit = (n_act >= 2);
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised NREAD x NWRITE register file with write priority and registered conflict flag.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH     = RF_WIDTH,
  parameter int ADDR_BITS = RF_ADDR_BITS,
  parameter int NREAD     = RF_NREAD,
  parameter int NWRITE    = RF_NWRITE,
  parameter int ZERO_REG  = 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [NREAD*ADDR_BITS-1:0]  ReadRegister,
  output logic [NREAD*WIDTH-1:0]      ReadData,
  input  logic [NWRITE*ADDR_BITS-1:0] WriteRegister,
  input  logic [NWRITE*WIDTH-1:0]     WriteData,
  input  logic [NWRITE-1:0]           wEnable,
  output logic                        WriteConflict
);

  localparam int DEPTH = 2**ADDR_BITS;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] wr_data [DEPTH];
  logic [DEPTH-1:0] wr_strobe;
  logic [DEPTH-1:0] multi_hit;

  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    localparam logic WRITABLE = !((ZERO_REG != 0) && (r == 0));
    logic [NWRITE-1:0] hit;
    logic              strobe_raw;
    logic              multi_raw;

    always_comb begin
      hit = '0;
      for (int j = 0; j < NWRITE; j++) begin
        hit[j] = (WriteRegister[j*ADDR_BITS +: ADDR_BITS] == ADDR_BITS'(r));
      end
    end

    regfile_write_select #(
      .WIDTH  (WIDTH),
      .NWRITE (NWRITE)
    ) u_sel (
      .hit       (hit),
      .en        (wEnable),
      .wdata     (WriteData),
      .strobe    (strobe_raw),
      .data      (wr_data[r]),
      .multi_hit (multi_raw)
    );

    // A hard-wired zero register can neither be written nor collide.
    assign wr_strobe[r] = strobe_raw & WRITABLE;
    assign multi_hit[r] = multi_raw & WRITABLE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      WriteConflict <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_strobe[i]) mem[i] <= wr_data[i];
      end
      WriteConflict <= |multi_hit;
    end
  end

  logic [ADDR_BITS-1:0] ra;
  logic [WIDTH-1:0]     rdat;

  always_comb begin
    ReadData = '0;
    ra       = '0;
    rdat     = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra   = ReadRegister[i*ADDR_BITS +: ADDR_BITS];
      rdat = mem[ra];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan leaves the highest-indexed matching port in place.
      if (!Reset) begin
        for (int j = 0; j < NWRITE; j++) begin
          if (wEnable[j] && (WriteRegister[j*ADDR_BITS +: ADDR_BITS] == ra)) begin
            rdat = WriteData[j*WIDTH +: WIDTH];
          end
        end
      end
`endif
      if ((ZERO_REG != 0) && (ra == '0)) rdat = '0;
      ReadData[i*WIDTH +: WIDTH] = rdat;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: ZERO_REG=1 and ZERO_REG=0 instances share stimulus.
module tb_regfile_multiport;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  rr;
  logic [63:0] rd, rd_z;
  logic [9:0]  wr;
  logic [63:0] wd;
  logic [1:0]  we;
  logic        wc, wc_z;

  regfile_multiport #(.WIDTH(32), .ADDR_BITS(5), .NREAD(2), .NWRITE(2), .ZERO_REG(1)) dut (
    .Clk(Clk), .Reset(Reset), .ReadRegister(rr), .ReadData(rd),
    .WriteRegister(wr), .WriteData(wd), .wEnable(we), .WriteConflict(wc)
  );

  regfile_multiport #(.WIDTH(32), .ADDR_BITS(5), .NREAD(2), .NWRITE(2), .ZERO_REG(0)) dut_z (
    .Clk(Clk), .Reset(Reset), .ReadRegister(rr), .ReadData(rd_z),
    .WriteRegister(wr), .WriteData(wd), .wEnable(we), .WriteConflict(wc_z)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem_m [32];
  logic [31:0] mem_z [32];
  logic        m_wc, m_wc_z;
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit zero);
    logic [31:0] v;
    v = zero ? mem_m[a] : mem_z[a];
    if (BYPASS && !Reset) begin
      for (int j = 0; j < 2; j++) begin
        if (we[j] && wr[j*5 +: 5] == a) v = wd[j*32 +: 32];
      end
    end
    if (zero && a == 5'd0) v = 32'd0;
    return v;
  endfunction

  // Advance the reference model for the edge, then step past it.
  task automatic tick;
    logic [4:0] a;
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_m[i] = 32'd0;
        mem_z[i] = 32'd0;
      end
      m_wc = 1'b0;
      m_wc_z = 1'b0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (we[j]) begin
          a = wr[j*5 +: 5];
          mem_z[a] = wd[j*32 +: 32];
          if (a != 5'd0) mem_m[a] = wd[j*32 +: 32];
        end
      end
      m_wc_z = (we == 2'b11) && (wr[4:0] == wr[9:5]);
      m_wc   = m_wc_z && (wr[4:0] != 5'd0);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    Reset = 1'b0; we = 2'b01; wr = {5'd0, 5'd5}; wd = {32'd0, 32'd42}; rr = {5'd5, 5'd5};
    tick();
    we = 2'b00;
    #1;
    exp_q.push_back(32'd42);
    e = exp_q.pop_front(); n_checks++;
    if (rd[31:0] !== e) begin n_fail++; $display("FAIL pre_reset_r5: got %0d expected %0d", rd[31:0], e); end
    Reset = 1'b1; we = 2'b01; wr = {5'd0, 5'd6}; wd = {32'd0, 32'd77};
    tick();
    Reset = 1'b0; we = 2'b00;
    for (int a = 0; a < 32; a++) begin
      rr = {5'(a), 5'(a)};
      #1;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); n_checks++;
      if (rd[31:0] !== e) begin n_fail++; $display("FAIL reset_rd r%0d: got %0d expected %0d", a, rd[31:0], e); end
      e = exp_q.pop_front(); n_checks++;
      if (rd_z[63:32] !== e) begin n_fail++; $display("FAIL reset_rd_z r%0d: got %0d expected %0d", a, rd_z[63:32], e); end
    end
    n_checks++;
    if (wc !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b expected 0", wc); end
  endtask

  task automatic test_write;
    logic [31:0] e;
    we = 2'b01; wr = {5'd0, 5'd2}; wd = {32'd0, 32'd42}; rr = {5'd2, 5'd2};
    #1;
    exp_q.push_back(BYPASS ? 32'd42 : 32'd0);
    exp_q.push_back(BYPASS ? 32'd42 : 32'd0);
    e = exp_q.pop_front(); n_checks++;
    if (rd[31:0] !== e) begin n_fail++; $display("FAIL write_pre_p0: got %0d expected %0d", rd[31:0], e); end
    e = exp_q.pop_front(); n_checks++;
    if (rd[63:32] !== e) begin n_fail++; $display("FAIL write_pre_p1: got %0d expected %0d", rd[63:32], e); end
    tick();
    we = 2'b00;
    #1;
    exp_q.push_back(32'd42);
    exp_q.push_back(32'd42);
    e = exp_q.pop_front(); n_checks++;
    if (rd[31:0] !== e) begin n_fail++; $display("FAIL write_post_p0: got %0d expected %0d", rd[31:0], e); end
    e = exp_q.pop_front(); n_checks++;
    if (rd[63:32] !== e) begin n_fail++; $display("FAIL write_post_p1: got %0d expected %0d", rd[63:32], e); end
  endtask

  task automatic test_conflict;
    logic [31:0] e;
    we = 2'b11; wr = {5'd12, 5'd12}; wd = {32'd99, 32'd15};
    tick();
    we = 2'b00; rr = {5'd12, 5'd12};
    #1;
    exp_q.push_back(32'd99);
    e = exp_q.pop_front(); n_checks++;
    if (rd[31:0] !== e) begin n_fail++; $display("FAIL conflict_data: got %0d expected %0d", rd[31:0], e); end
    n_checks++;
    if (wc !== 1'b1) begin n_fail++; $display("FAIL conflict_flag: got %b expected 1", wc); end
    tick();
    n_checks++;
    if (wc !== 1'b0) begin n_fail++; $display("FAIL conflict_clear: got %b expected 0", wc); end
  endtask

  task automatic test_zero_reg;
    logic [31:0] e;
    we = 2'b11; wr = {5'd0, 5'd0}; wd = {32'd66, 32'd55};
    tick();
    we = 2'b00; rr = {5'd0, 5'd0};
    #1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd66);
    e = exp_q.pop_front(); n_checks++;
    if (rd[31:0] !== e) begin n_fail++; $display("FAIL zero_reg_rd: got %0d expected %0d", rd[31:0], e); end
    e = exp_q.pop_front(); n_checks++;
    if (rd_z[31:0] !== e) begin n_fail++; $display("FAIL ordinary_r0_rd: got %0d expected %0d", rd_z[31:0], e); end
    n_checks++;
    if (wc !== 1'b0) begin n_fail++; $display("FAIL zero_reg_conflict: got %b expected 0", wc); end
    n_checks++;
    if (wc_z !== 1'b1) begin n_fail++; $display("FAIL ordinary_r0_conflict: got %b expected 1", wc_z); end
  endtask

  task automatic test_comb_read;
    logic [31:0] e;
    we = 2'b11; wr = {5'd12, 5'd11}; wd = {32'd42, 32'd40};
    tick();
    we = 2'b00; rr = {5'd12, 5'd11};
    #1;
    exp_q.push_back(32'd40);
    exp_q.push_back(32'd42);
    e = exp_q.pop_front(); n_checks++;
    if (rd[31:0] !== e) begin n_fail++; $display("FAIL comb_r11: got %0d expected %0d", rd[31:0], e); end
    e = exp_q.pop_front(); n_checks++;
    if (rd[63:32] !== e) begin n_fail++; $display("FAIL comb_r12: got %0d expected %0d", rd[63:32], e); end
    n_checks++;
    if (wc !== 1'b0) begin n_fail++; $display("FAIL comb_no_conflict: got %b expected 0", wc); end
    rr = 10'd0;
    #1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_checks++;
    if (rd[31:0] !== e) begin n_fail++; $display("FAIL comb_to_r0_p0: got %0d expected %0d", rd[31:0], e); end
    e = exp_q.pop_front(); n_checks++;
    if (rd[63:32] !== e) begin n_fail++; $display("FAIL comb_to_r0_p1: got %0d expected %0d", rd[63:32], e); end
  endtask

  task automatic test_bypass;
    logic [31:0] e;
    we = 2'b01; wr = {5'd0, 5'd3}; wd = {32'd0, 32'd5};
    tick();
    wd = {32'd0, 32'd7}; rr = {5'd3, 5'd3};
    #1;
    exp_q.push_back(BYPASS ? 32'd7 : 32'd5);
    e = exp_q.pop_front(); n_checks++;
    if (rd[31:0] !== e) begin n_fail++; $display("FAIL bypass_pre_edge: got %0d expected %0d", rd[31:0], e); end
    Reset = 1'b1;
    #1;
    exp_q.push_back(32'd5);
    e = exp_q.pop_front(); n_checks++;
    if (rd[31:0] !== e) begin n_fail++; $display("FAIL bypass_in_reset: got %0d expected %0d", rd[31:0], e); end
    tick();
    Reset = 1'b0; we = 2'b00;
    #1;
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_checks++;
    if (rd[31:0] !== e) begin n_fail++; $display("FAIL reset_drops_write: got %0d expected %0d", rd[31:0], e); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    for (int it = 0; it < 300; it++) begin
      Reset = ($urandom_range(0, 24) == 0);
      we    = 2'($urandom_range(0, 3));
      wr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wd    = {$urandom, $urandom};
      rr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      exp_q.push_back(exp_read(rr[4:0], 1'b1));
      exp_q.push_back(exp_read(rr[9:5], 1'b1));
      exp_q.push_back(exp_read(rr[4:0], 1'b0));
      exp_q.push_back(exp_read(rr[9:5], 1'b0));
      e = exp_q.pop_front(); n_checks++;
      if (rd[31:0] !== e) begin n_fail++; $display("FAIL b2b_rd0 it%0d: got %h expected %h", it, rd[31:0], e); end
      e = exp_q.pop_front(); n_checks++;
      if (rd[63:32] !== e) begin n_fail++; $display("FAIL b2b_rd1 it%0d: got %h expected %h", it, rd[63:32], e); end
      e = exp_q.pop_front(); n_checks++;
      if (rd_z[31:0] !== e) begin n_fail++; $display("FAIL b2b_rdz0 it%0d: got %h expected %h", it, rd_z[31:0], e); end
      e = exp_q.pop_front(); n_checks++;
      if (rd_z[63:32] !== e) begin n_fail++; $display("FAIL b2b_rdz1 it%0d: got %h expected %h", it, rd_z[63:32], e); end
      tick();
      n_checks++;
      if (wc !== m_wc) begin n_fail++; $display("FAIL b2b_conflict it%0d: got %b expected %b", it, wc, m_wc); end
      n_checks++;
      if (wc_z !== m_wc_z) begin n_fail++; $display("FAIL b2b_conflict_z it%0d: got %b expected %b", it, wc_z, m_wc_z); end
    end
  endtask

  initial begin
    Reset = 1'b1; we = 2'b00; wr = '0; wd = '0; rr = '0;
    tick();
    test_reset();
    test_write();
    test_conflict();
    test_zero_reg();
    test_comb_read();
    test_bypass();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
